// File: rtl/mcp_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, FSM state codes, select encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mcp_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // FSM state encodings; 13..15 are never entered
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;
    localparam logic [3:0] S_BNEEX   = 4'd12;

    // Named view of the same encodings for debug / waveform readability
    typedef enum logic [3:0] {
        ST_FETCH   = S_FETCH,
        ST_DECODE  = S_DECODE,
        ST_MEMADR  = S_MEMADR,
        ST_MEMRD   = S_MEMRD,
        ST_MEMWB   = S_MEMWB,
        ST_MEMWR   = S_MEMWR,
        ST_RTYPEEX = S_RTYPEEX,
        ST_RTYPEWB = S_RTYPEWB,
        ST_BEQEX   = S_BEQEX,
        ST_ADDIEX  = S_ADDIEX,
        ST_ADDIWB  = S_ADDIWB,
        ST_JEX     = S_JEX,
        ST_BNEEX   = S_BNEEX
    } state_t;

    // Next-PC select
    localparam logic [1:0] PCSEL_ALU    = 2'b00;
    localparam logic [1:0] PCSEL_ALUOUT = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] BSEL_REG    = 2'b00;
    localparam logic [1:0] BSEL_FOUR   = 2'b01;
    localparam logic [1:0] BSEL_IMM    = 2'b10;
    localparam logic [1:0] BSEL_IMM_SH = 2'b11;

    // ALU operation override
    localparam logic [1:0] ALT_ADD   = 2'b00;
    localparam logic [1:0] ALT_SUB   = 2'b01;
    localparam logic [1:0] ALT_FUNCT = 2'b10;

    // Control word decoded from the current state. pc_we is the unconditional
    // PC write; branch_eq / branch_ne request a write qualified by the zero flag.
    typedef struct packed {
        logic       pc_we;
        logic       branch_eq;
        logic       branch_ne;
        logic [1:0] pc_branch;
        logic       instr_or_data;
        logic       instr_we;
        logic       mem_we;
        logic       reg_dst_rtrd;
        logic       mem_to_reg;
        logic       enable_wrf;
        logic       a_alu;
        logic [1:0] b_alu;
        logic [1:0] alt_ctrl;
    } ctrl_t;

endpackage

// File: rtl/mc_state_dec.sv
// Purpose: combinational state -> control word decode for the multicycle FSM (MC_BNE_EN adds BNEEX).
// Latency: zero cycles, pure combinational.
// Backpressure: none; the decode has no handshake.
module mc_state_dec
    import mcp_pkg::*;
(
    input  logic [3:0] state_i,
    output ctrl_t      ctrl_o
);

    // Moore decode: every field defaults to 0, so unused encodings assert nothing
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.instr_or_data = 1'b0;
                ctrl_o.instr_we      = 1'b1;
                ctrl_o.a_alu         = 1'b0;
                ctrl_o.b_alu         = BSEL_FOUR;
                ctrl_o.alt_ctrl      = ALT_ADD;
                ctrl_o.pc_branch     = PCSEL_ALU;
                ctrl_o.pc_we         = 1'b1;
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut while the opcode is examined
                ctrl_o.a_alu    = 1'b0;
                ctrl_o.b_alu    = BSEL_IMM_SH;
                ctrl_o.alt_ctrl = ALT_ADD;
            end
            S_MEMADR: begin
                ctrl_o.a_alu    = 1'b1;
                ctrl_o.b_alu    = BSEL_IMM;
                ctrl_o.alt_ctrl = ALT_ADD;
            end
            S_MEMRD: begin
                ctrl_o.instr_or_data = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_dst_rtrd = 1'b0;
                ctrl_o.mem_to_reg   = 1'b1;
                ctrl_o.enable_wrf   = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.instr_or_data = 1'b1;
                ctrl_o.mem_we        = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl_o.a_alu    = 1'b1;
                ctrl_o.b_alu    = BSEL_REG;
                ctrl_o.alt_ctrl = ALT_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl_o.reg_dst_rtrd = 1'b1;
                ctrl_o.mem_to_reg   = 1'b0;
                ctrl_o.enable_wrf   = 1'b1;
            end
            S_BEQEX: begin
                ctrl_o.a_alu     = 1'b1;
                ctrl_o.b_alu     = BSEL_REG;
                ctrl_o.alt_ctrl  = ALT_SUB;
                ctrl_o.pc_branch = PCSEL_ALUOUT;
                ctrl_o.branch_eq = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNEEX: begin
                ctrl_o.a_alu     = 1'b1;
                ctrl_o.b_alu     = BSEL_REG;
                ctrl_o.alt_ctrl  = ALT_SUB;
                ctrl_o.pc_branch = PCSEL_ALUOUT;
                ctrl_o.branch_ne = 1'b1;
            end
`endif
            S_ADDIEX: begin
                ctrl_o.a_alu    = 1'b1;
                ctrl_o.b_alu    = BSEL_IMM;
                ctrl_o.alt_ctrl = ALT_ADD;
            end
            S_ADDIWB: begin
                ctrl_o.reg_dst_rtrd = 1'b0;
                ctrl_o.mem_to_reg   = 1'b0;
                ctrl_o.enable_wrf   = 1'b1;
            end
            S_JEX: begin
                ctrl_o.pc_branch = PCSEL_JUMP;
                ctrl_o.pc_we     = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Purpose: multicycle MIPS control FSM; state register, next-state and write-enable gating (MC_BNE_EN adds bne).
// Latency: one state per cycle; lw 5, sw/R/addi 4, beq/bne/j 3 cycles including FETCH.
// Backpressure: none; the FSM never stalls, and reset_ni low masks every write enable combinationally.
module mc_controller
    import mcp_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [5:0] opcode_i6,
    input  logic       zero_i,
    output logic       pc_we_o,
    output logic [1:0] pc_branch_o2,
    output logic       instr_or_data_o,
    output logic       instr_we_o,
    output logic       mem_we_o,
    output logic       reg_dst_rtrd_o,
    output logic       mem_to_reg_o,
    output logic       enable_wrf_o,
    output logic       a_alu_input_o,
    output logic [1:0] b_alu_input_o2,
    output logic [1:0] alu_alt_ctrl_o2,
    output logic       illegal_o,
    output logic [3:0] state_o4
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       illegal;
    ctrl_t      ctrl;

    // State register; reset parks the FSM in FETCH without waiting for a clock
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unknown opcodes in DECODE and stray encodings fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i6)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            // IR is stable through the instruction, so the opcode still picks load vs store here
            S_MEMADR:  state_d = (opcode_i6 == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_state_dec u_state_dec (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    // Write enables are masked while reset is low so nothing is committed mid-abort;
    // selects are left as decoded (FETCH values while in reset).
    assign pc_we_o         = reset_ni & (ctrl.pc_we
                                       | (ctrl.branch_eq &  zero_i)
                                       | (ctrl.branch_ne & ~zero_i));
    assign instr_we_o      = reset_ni & ctrl.instr_we;
    assign mem_we_o        = reset_ni & ctrl.mem_we;
    assign enable_wrf_o    = reset_ni & ctrl.enable_wrf;
    assign illegal_o       = reset_ni & illegal;

    assign pc_branch_o2    = ctrl.pc_branch;
    assign instr_or_data_o = ctrl.instr_or_data;
    assign reg_dst_rtrd_o  = ctrl.reg_dst_rtrd;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign a_alu_input_o   = ctrl.a_alu;
    assign b_alu_input_o2  = ctrl.b_alu;
    assign alu_alt_ctrl_o2 = ctrl.alt_ctrl;
    assign state_o4        = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through the FSM.
// Expected states and control values are written out by hand below.
// Build with +define+MC_BNE_EN to exercise the bne path.
module tb_mc_controller;
    import mcp_pkg::*;

    logic       clk_i;
    logic       reset_ni;
    logic [5:0] opcode_i6;
    logic       zero_i;
    logic       pc_we_o;
    logic [1:0] pc_branch_o2;
    logic       instr_or_data_o;
    logic       instr_we_o;
    logic       mem_we_o;
    logic       reg_dst_rtrd_o;
    logic       mem_to_reg_o;
    logic       enable_wrf_o;
    logic       a_alu_input_o;
    logic [1:0] b_alu_input_o2;
    logic [1:0] alu_alt_ctrl_o2;
    logic       illegal_o;
    logic [3:0] state_o4;

    int n_checks = 0;
    int n_fail   = 0;

    mc_controller dut (
        .clk_i           (clk_i),
        .reset_ni        (reset_ni),
        .opcode_i6       (opcode_i6),
        .zero_i          (zero_i),
        .pc_we_o         (pc_we_o),
        .pc_branch_o2    (pc_branch_o2),
        .instr_or_data_o (instr_or_data_o),
        .instr_we_o      (instr_we_o),
        .mem_we_o        (mem_we_o),
        .reg_dst_rtrd_o  (reg_dst_rtrd_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .enable_wrf_o    (enable_wrf_o),
        .a_alu_input_o   (a_alu_input_o),
        .b_alu_input_o2  (b_alu_input_o2),
        .alu_alt_ctrl_o2 (alu_alt_ctrl_o2),
        .illegal_o       (illegal_o),
        .state_o4        (state_o4)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enables packed as {pc_we, instr_we, mem_we, enable_wrf, illegal}
    task automatic chk_en(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, pc_we_o, instr_we_o, mem_we_o, enable_wrf_o, illegal_o}, {27'd0, exp});
    endtask

    task automatic chk_st(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, state_o4}, {28'd0, exp});
    endtask

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_ni  = 1'b0;
        opcode_i6 = OP_LW;
        zero_i    = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk_i);
        #1;
        chk_st("rst_state", S_FETCH);
        chk_en("rst_en", 5'b00000);
        chk("rst_bsel", b_alu_input_o2, BSEL_FOUR);
        chk("rst_asel", a_alu_input_o, 1'b0);
        chk("rst_iord", instr_or_data_o, 1'b0);

        // Release away from the edge; first FETCH is live immediately
        @(negedge clk_i);
        reset_ni = 1'b1;
        #1;

        // lw: FETCH DECODE MEMADR MEMRD MEMWB
        chk_st("lw_c1_state", S_FETCH);
        chk_en("lw_c1_en", 5'b11000);
        tick();
        chk_st("lw_c2_state", S_DECODE);
        chk_en("lw_c2_en", 5'b00000);
        chk("lw_c2_bsel", b_alu_input_o2, BSEL_IMM_SH);
        tick();
        chk_st("lw_c3_state", S_MEMADR);
        chk("lw_c3_asel", a_alu_input_o, 1'b1);
        chk("lw_c3_bsel", b_alu_input_o2, BSEL_IMM);
        chk_en("lw_c3_en", 5'b00000);
        tick();
        chk_st("lw_c4_state", S_MEMRD);
        chk("lw_c4_iord", instr_or_data_o, 1'b1);
        chk_en("lw_c4_en", 5'b00000);
        tick();
        chk_st("lw_c5_state", S_MEMWB);
        chk_en("lw_c5_en", 5'b00010);
        chk("lw_c5_m2r", mem_to_reg_o, 1'b1);
        chk("lw_c5_dst", reg_dst_rtrd_o, 1'b0);
        tick();

        // sw: FETCH DECODE MEMADR MEMWR
        opcode_i6 = OP_SW;
        chk_st("sw_c1_state", S_FETCH);
        chk_en("sw_c1_en", 5'b11000);
        tick();
        chk_en("sw_c2_en", 5'b00000);
        tick();
        chk_st("sw_c3_state", S_MEMADR);
        chk_en("sw_c3_en", 5'b00000);
        tick();
        chk_st("sw_c4_state", S_MEMWR);
        chk_en("sw_c4_en", 5'b00100);
        chk("sw_c4_iord", instr_or_data_o, 1'b1);
        tick();

        // R-type, with reset dropped during write-back
        opcode_i6 = OP_RTYPE;
        chk_st("r_c1_state", S_FETCH);
        tick();
        tick();
        chk_st("r_c3_state", S_RTYPEEX);
        chk("r_c3_alt", alu_alt_ctrl_o2, ALT_FUNCT);
        chk("r_c3_bsel", b_alu_input_o2, BSEL_REG);
        chk("r_c3_asel", a_alu_input_o, 1'b1);
        tick();
        chk_st("r_c4_state", S_RTYPEWB);
        chk_en("r_c4_en", 5'b00010);
        chk("r_c4_dst", reg_dst_rtrd_o, 1'b1);
        chk("r_c4_m2r", mem_to_reg_o, 1'b0);
        reset_ni = 1'b0;
        #1;
        chk("r_abort_wrf", enable_wrf_o, 1'b0);
        chk_st("r_abort_state", S_FETCH);
        tick();
        chk_en("r_abort_hold_en", 5'b00000);
        @(negedge clk_i);
        reset_ni = 1'b1;
        #1;
        chk_st("r_rel_state", S_FETCH);
        chk_en("r_rel_en", 5'b11000);

        // beq taken then not taken within BEQEX
        opcode_i6 = OP_BEQ;
        tick();
        chk_st("beq_c2_state", S_DECODE);
        tick();
        chk_st("beq_c3_state", S_BEQEX);
        zero_i = 1'b1;
        #1;
        chk_en("beq_taken_en", 5'b10000);
        chk("beq_pcsel", pc_branch_o2, PCSEL_ALUOUT);
        chk("beq_alt", alu_alt_ctrl_o2, ALT_SUB);
        zero_i = 1'b0;
        #1;
        chk_en("beq_nt_en", 5'b00000);
        tick();
        chk_st("beq_done_state", S_FETCH);

        // addi
        opcode_i6 = OP_ADDI;
        tick();
        tick();
        chk_st("addi_c3_state", S_ADDIEX);
        chk("addi_c3_bsel", b_alu_input_o2, BSEL_IMM);
        tick();
        chk_st("addi_c4_state", S_ADDIWB);
        chk_en("addi_c4_en", 5'b00010);
        chk("addi_c4_dst", reg_dst_rtrd_o, 1'b0);
        tick();

        // j
        opcode_i6 = OP_J;
        tick();
        tick();
        chk_st("j_c3_state", S_JEX);
        chk_en("j_c3_en", 5'b10000);
        chk("j_c3_pcsel", pc_branch_o2, PCSEL_JUMP);
        tick();
        chk_st("j_done_state", S_FETCH);

        // Unknown opcode
        opcode_i6 = 6'b111111;
        tick();
        chk_st("ill_state", S_DECODE);
        chk_en("ill_en", 5'b00001);
        tick();
        chk_st("ill_next_state", S_FETCH);
        chk_en("ill_next_en", 5'b11000);

        // bne
        opcode_i6 = OP_BNE;
        zero_i    = 1'b0;
        tick();
`ifdef MC_BNE_EN
        chk_en("bne_dec_en", 5'b00000);
        tick();
        chk_st("bne_state", S_BNEEX);
        chk_en("bne_taken_en", 5'b10000);
        chk("bne_pcsel", pc_branch_o2, PCSEL_ALUOUT);
        zero_i = 1'b1;
        #1;
        chk_en("bne_nt_en", 5'b00000);
        tick();
        chk_st("bne_done_state", S_FETCH);
`else
        chk_en("bne_ill_en", 5'b00001);
        tick();
        chk_st("bne_ill_next", S_FETCH);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
